vx_dcache_req_sched: RTL and testbench

- Shares one multi-lane D$ request/response port between NUM_REQS requesters (LSU, plus future texture/raster/prefetch engines).
- Round-robin arbitration with a grant lock. A requester whose lanes are only partially accepted keeps the port until all its lanes are sent.
- Appends the requester index to the tag and routes responses back by that index.
- Tracks outstanding load lanes per requester for fence and drain.

---
 rtl/vx_dcache_req_sched_pkg.sv | 21 ++
 rtl/vx_dcache_req_sched_rr_arbiter.sv | 49 ++++
 rtl/vx_dcache_req_sched.sv | 201 ++++++++++++++++++++
 tb/tb_vx_dcache_req_sched.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_dcache_req_sched_pkg.sv
// Shared widths and state encoding for the D$ request scheduler.
// The constants are the values for the default configuration of two requesters and 16-bit tags.
package vx_dcache_req_sched_pkg;

  function automatic int sched_sel_bits(input int num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 1;
  endfunction

  function automatic int sched_tag_out_width(input int tag_in_width, input int num_reqs);
    return tag_in_width + sched_sel_bits(num_reqs);
  endfunction

  localparam int SCHED_SEL_BITS      = sched_sel_bits(2);
  localparam int SCHED_TAG_OUT_WIDTH = sched_tag_out_width(16, 2);

  typedef enum logic {
    SCHED_IDLE   = 1'b0,
    SCHED_LOCKED = 1'b1
  } sched_state_e;

endpackage

// File: rtl/vx_dcache_req_sched_rr_arbiter.sv
// Round-robin picker with a lock override.
// The pointer moves past the winner only when its request completes.
module vx_dcache_req_sched_rr_arbiter
  import vx_dcache_req_sched_pkg::*;
#(
  parameter int NUM_REQS = 2,
  localparam int SEL_BITS = sched_sel_bits(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] eligible,
  input  logic                lock_valid,
  input  logic [SEL_BITS-1:0] lock_sel,
  input  logic                advance,
  output logic                grant_valid,
  output logic [SEL_BITS-1:0] grant_idx
);

  logic [SEL_BITS-1:0] rr_ptr;
  logic [SEL_BITS-1:0] pick_idx;
  logic                pick_valid;

  // Scan downward so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    logic [SEL_BITS-1:0] cand;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      cand = SEL_BITS'((int'(rr_ptr) + i) % NUM_REQS);
      if (eligible[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign grant_valid = lock_valid | pick_valid;
  assign grant_idx   = lock_valid ? lock_sel : pick_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (int'(grant_idx) == NUM_REQS - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/vx_dcache_req_sched.sv
// Shares one multi-lane D$ port among several requesters with a grant lock,
// tags requests with the requester index and routes responses back by it.
module vx_dcache_req_sched
  import vx_dcache_req_sched_pkg::*;
#(
  parameter int NUM_REQS     = 2,
  parameter int NUM_LANES    = 4,
  parameter int ADDR_WIDTH   = 30,
  parameter int WORD_SIZE    = 4,
  parameter int TAG_IN_WIDTH = 16,
  parameter int MAX_PENDING  = 16,
  localparam int SEL_BITS      = sched_sel_bits(NUM_REQS),
  localparam int TAG_OUT_WIDTH = sched_tag_out_width(TAG_IN_WIDTH, NUM_REQS),
  localparam int DW            = WORD_SIZE * 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_REQS*NUM_LANES-1:0]              req_valid_in,
  input  logic [NUM_REQS*NUM_LANES-1:0]              req_rw_in,
  input  logic [NUM_REQS*NUM_LANES*ADDR_WIDTH-1:0]   req_addr_in,
  input  logic [NUM_REQS*NUM_LANES*WORD_SIZE-1:0]    req_byteen_in,
  input  logic [NUM_REQS*NUM_LANES*DW-1:0]           req_data_in,
  input  logic [NUM_REQS*NUM_LANES*TAG_IN_WIDTH-1:0] req_tag_in,
  output logic [NUM_REQS*NUM_LANES-1:0]              req_ready_in,
  output logic [NUM_LANES-1:0]                       req_valid_out,
  output logic [NUM_LANES-1:0]                       req_rw_out,
  output logic [NUM_LANES*ADDR_WIDTH-1:0]            req_addr_out,
  output logic [NUM_LANES*WORD_SIZE-1:0]             req_byteen_out,
  output logic [NUM_LANES*DW-1:0]                    req_data_out,
  output logic [NUM_LANES*TAG_OUT_WIDTH-1:0]         req_tag_out,
  input  logic [NUM_LANES-1:0]                       req_ready_out,
  input  logic                                       rsp_valid_in,
  input  logic [NUM_LANES-1:0]                       rsp_tmask_in,
  input  logic [NUM_LANES*DW-1:0]                    rsp_data_in,
  input  logic [TAG_OUT_WIDTH-1:0]                   rsp_tag_in,
  output logic                                       rsp_ready_in,
  output logic [NUM_REQS-1:0]                        rsp_valid_out,
  output logic [NUM_LANES-1:0]                       rsp_tmask_out,
  output logic [NUM_LANES*DW-1:0]                    rsp_data_out,
  output logic [TAG_IN_WIDTH-1:0]                    rsp_tag_out,
  input  logic [NUM_REQS-1:0]                        rsp_ready_out,
  output logic [NUM_REQS-1:0]                        pending_out
);

  localparam int CAP   = MAX_PENDING * NUM_LANES;
  localparam int CNT_W = $clog2(CAP + 1);

  function automatic int popcount(input logic [NUM_LANES-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NUM_LANES; i++) n += int'(v[i]);
    return n;
  endfunction

  // Floor at zero absorbs responses to loads issued before a reset.
  function automatic logic [CNT_W-1:0] sat_cnt(input int v);
    if (v < 0)   return '0;
    if (v > CAP) return CNT_W'(CAP);
    return CNT_W'(v);
  endfunction

  logic [NUM_LANES-1:0]                       valid_arr  [NUM_REQS];
  logic [NUM_LANES-1:0]                       rw_arr     [NUM_REQS];
  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0]       addr_arr   [NUM_REQS];
  logic [NUM_LANES-1:0][WORD_SIZE-1:0]        byteen_arr [NUM_REQS];
  logic [NUM_LANES-1:0][DW-1:0]               data_arr   [NUM_REQS];
  logic [NUM_LANES-1:0][TAG_IN_WIDTH-1:0]     tag_arr    [NUM_REQS];

  always_comb begin
    for (int r = 0; r < NUM_REQS; r++) begin
      valid_arr[r]  = req_valid_in[r*NUM_LANES +: NUM_LANES];
      rw_arr[r]     = req_rw_in[r*NUM_LANES +: NUM_LANES];
      addr_arr[r]   = req_addr_in[r*NUM_LANES*ADDR_WIDTH +: NUM_LANES*ADDR_WIDTH];
      byteen_arr[r] = req_byteen_in[r*NUM_LANES*WORD_SIZE +: NUM_LANES*WORD_SIZE];
      data_arr[r]   = req_data_in[r*NUM_LANES*DW +: NUM_LANES*DW];
      tag_arr[r]    = req_tag_in[r*NUM_LANES*TAG_IN_WIDTH +: NUM_LANES*TAG_IN_WIDTH];
    end
  end

  sched_state_e        state;
  logic [SEL_BITS-1:0] lock_sel;
  logic [SEL_BITS-1:0] sel;
  logic                grant_valid;
  logic                locked;
  logic                done;
  logic                partial;
  logic [NUM_REQS-1:0] eligible;
  logic [CNT_W-1:0]    cnt      [NUM_REQS];
  logic [CNT_W-1:0]    cnt_next [NUM_REQS];
  logic [NUM_LANES-1:0] valid_sel;
  logic [NUM_LANES-1:0] fire;
  logic [NUM_LANES-1:0] unsent;

  assign locked = (state == SCHED_LOCKED);

  // The headroom check protects the counter; a locked grant already passed it.
  always_comb begin
    eligible = '0;
    for (int r = 0; r < NUM_REQS; r++)
      eligible[r] = (|valid_arr[r]) && (int'(cnt[r]) <= CAP - NUM_LANES);
  end

  vx_dcache_req_sched_rr_arbiter #(
    .NUM_REQS (NUM_REQS)
  ) arbiter (
    .clk         (clk),
    .reset       (reset),
    .eligible    (eligible),
    .lock_valid  (locked),
    .lock_sel    (lock_sel),
    .advance     (done),
    .grant_valid (grant_valid),
    .grant_idx   (sel)
  );

  assign valid_sel      = grant_valid ? valid_arr[sel] : '0;
  assign fire           = valid_sel & req_ready_out;
  assign unsent         = valid_sel & ~req_ready_out;
  assign req_valid_out  = valid_sel;
  assign req_rw_out     = rw_arr[sel];
  assign req_addr_out   = addr_arr[sel];
  assign req_byteen_out = byteen_arr[sel];
  assign req_data_out   = data_arr[sel];

  always_comb begin
    req_tag_out = '0;
    for (int l = 0; l < NUM_LANES; l++)
      req_tag_out[l*TAG_OUT_WIDTH +: TAG_OUT_WIDTH] = {tag_arr[sel][l], sel};
  end

  always_comb begin
    req_ready_in = '0;
    for (int r = 0; r < NUM_REQS; r++)
      if (grant_valid && sel == SEL_BITS'(r))
        req_ready_in[r*NUM_LANES +: NUM_LANES] = req_ready_out;
  end

  // A locked requester that withdraws every lane also ends its grant.
  assign done    = grant_valid && (unsent == '0) && ((|valid_sel) || locked);
  assign partial = grant_valid && (unsent != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= SCHED_IDLE;
      lock_sel <= '0;
    end else if (partial) begin
      state    <= SCHED_LOCKED;
      lock_sel <= sel;
    end else if (done) begin
      state    <= SCHED_IDLE;
    end
  end

  logic [SEL_BITS-1:0] rsel;
  logic                rsel_ok;
  logic                rsp_fire;

  assign rsel          = rsp_tag_in[SEL_BITS-1:0];
  assign rsel_ok       = (int'(rsel) < NUM_REQS);
  assign rsp_fire      = rsp_valid_in && rsp_ready_in;
  assign rsp_tmask_out = rsp_tmask_in;
  assign rsp_data_out  = rsp_data_in;
  assign rsp_tag_out   = rsp_tag_in[TAG_OUT_WIDTH-1:SEL_BITS];

  always_comb begin
    rsp_valid_out = '0;
    rsp_ready_in  = 1'b1;
    if (rsel_ok) begin
      rsp_valid_out[rsel] = rsp_valid_in;
      rsp_ready_in        = rsp_ready_out[rsel];
    end
  end

  always_comb begin
    int inc;
    int dec;
    inc = 0;
    dec = 0;
    for (int r = 0; r < NUM_REQS; r++) begin
      inc = (sel == SEL_BITS'(r)) ? popcount(fire & ~rw_arr[r]) : 0;
      dec = (rsp_fire && rsel_ok && rsel == SEL_BITS'(r)) ? popcount(rsp_tmask_in) : 0;
      cnt_next[r] = sat_cnt(int'(cnt[r]) + inc - dec);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REQS; r++) cnt[r] <= '0;
      pending_out <= '0;
    end else begin
      for (int r = 0; r < NUM_REQS; r++) begin
        cnt[r]         <= cnt_next[r];
        pending_out[r] <= (cnt_next[r] != '0);
      end
    end
  end

  assert property (@(posedge clk) disable iff (!reset) rsp_valid_in |-> rsel_ok)
    else $error("vx_dcache_req_sched: response for nonexistent requester %0d", rsel);

endmodule

// File: tb/tb_vx_dcache_req_sched.sv
// Directed scoreboard bench for vx_dcache_req_sched (2 requesters, 4 lanes).
module tb_vx_dcache_req_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   req_valid_in, req_rw_in, req_ready_in;
  logic [239:0] req_addr_in;
  logic [31:0]  req_byteen_in;
  logic [255:0] req_data_in;
  logic [127:0] req_tag_in;
  logic [3:0]   req_valid_out, req_rw_out, req_ready_out;
  logic [119:0] req_addr_out;
  logic [15:0]  req_byteen_out;
  logic [127:0] req_data_out;
  logic [67:0]  req_tag_out;
  logic         rsp_valid_in, rsp_ready_in;
  logic [3:0]   rsp_tmask_in, rsp_tmask_out;
  logic [127:0] rsp_data_in, rsp_data_out;
  logic [16:0]  rsp_tag_in;
  logic [15:0]  rsp_tag_out;
  logic [1:0]   rsp_valid_out, rsp_ready_out, pending_out;

  vx_dcache_req_sched dut (
    .clk(clk), .reset(reset),
    .req_valid_in(req_valid_in), .req_rw_in(req_rw_in), .req_addr_in(req_addr_in),
    .req_byteen_in(req_byteen_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .req_ready_in(req_ready_in),
    .req_valid_out(req_valid_out), .req_rw_out(req_rw_out), .req_addr_out(req_addr_out),
    .req_byteen_out(req_byteen_out), .req_data_out(req_data_out), .req_tag_out(req_tag_out),
    .req_ready_out(req_ready_out),
    .rsp_valid_in(rsp_valid_in), .rsp_tmask_in(rsp_tmask_in), .rsp_data_in(rsp_data_in),
    .rsp_tag_in(rsp_tag_in), .rsp_ready_in(rsp_ready_in),
    .rsp_valid_out(rsp_valid_out), .rsp_tmask_out(rsp_tmask_out), .rsp_data_out(rsp_data_out),
    .rsp_tag_out(rsp_tag_out), .rsp_ready_out(rsp_ready_out), .pending_out(pending_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  valid;
    logic        sel;
    logic [7:0]  ready;
    logic [29:0] addr0;
  } req_exp_t;

  typedef struct packed {
    logic [1:0]  valid;
    logic        ready;
    logic [15:0] tag;
  } rsp_exp_t;

  req_exp_t req_q[$];
  rsp_exp_t rsp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Request/response monitors pop the scoreboard whenever the DUT presents something.
  always @(negedge clk) begin
    if (reset === 1'b1 && |req_valid_out) begin
      req_exp_t g, e;
      g = {req_valid_out, req_tag_out[0], req_ready_in, req_addr_out[29:0]};
      if (req_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL req_unexpected: got %h expected none", g);
      end else begin
        e = req_q.pop_front();
        check("req_grant", 64'(g), 64'(e));
      end
    end
    if (reset === 1'b1 && |rsp_valid_out) begin
      rsp_exp_t g, e;
      g = {rsp_valid_out, rsp_ready_in, rsp_tag_out};
      if (rsp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected: got %h expected none", g);
      end else begin
        e = rsp_q.pop_front();
        check("rsp_route", 64'(g), 64'(e));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [3:0] v, input logic [3:0] rw, input logic [29:0] base);
    for (int l = 0; l < 4; l++) begin
      req_valid_in[r*4+l]               = v[l];
      req_rw_in[r*4+l]                  = rw[l];
      req_addr_in[(r*4+l)*30 +: 30]     = base + 30'(l);
      req_byteen_in[(r*4+l)*4 +: 4]     = 4'hF;
      req_data_in[(r*4+l)*32 +: 32]     = 32'(base) + 32'(l);
      req_tag_in[(r*4+l)*16 +: 16]      = 16'(base) + 16'(l);
    end
  endtask

  task automatic clear_req();
    req_valid_in = '0; req_rw_in = '0; req_addr_in = '0;
    req_byteen_in = '0; req_data_in = '0; req_tag_in = '0;
  endtask

  task automatic push_req(input logic sel, input logic [3:0] v, input logic [7:0] rdy, input logic [29:0] a0);
    req_exp_t e;
    e = {v, sel, rdy, a0};
    req_q.push_back(e);
  endtask

  task automatic send_rsp(input logic [3:0] tmask, input logic [15:0] tag, input logic sel,
                          input logic [1:0] rdy_out, input logic exp_ready);
    rsp_exp_t e;
    rsp_valid_in  = 1'b1;
    rsp_tmask_in  = tmask;
    rsp_tag_in    = {tag, sel};
    rsp_data_in   = {4{16'h0, tag}};
    rsp_ready_out = rdy_out;
    e = {(sel ? 2'b10 : 2'b01), exp_ready, tag};
    rsp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b0;
    clear_req();
    req_ready_out = '0;
    rsp_valid_in = 1'b0; rsp_tmask_in = '0; rsp_data_in = '0; rsp_tag_in = '0;
    rsp_ready_out = '0;
    repeat (2) cyc();
    check("rst_valid_out", 64'(req_valid_out), 64'h0);
    check("rst_ready_in", 64'(req_ready_in), 64'h0);
    check("rst_pending", 64'(pending_out), 64'h0);
    reset = 1'b1;
    cyc();

    // Both requesters storing every cycle: grants alternate 0,1,0,1.
    set_req(0, 4'hF, 4'hF, 30'h100);
    set_req(1, 4'hF, 4'hF, 30'h200);
    req_ready_out = 4'hF;
    for (int i = 0; i < 4; i++) begin
      push_req(1'(i % 2), 4'hF, (i % 2) ? 8'hF0 : 8'h0F, (i % 2) ? 30'h200 : 30'h100);
      cyc();
    end
    clear_req();
    cyc();

    // Partial acceptance locks req0 until its remaining lanes fire.
    set_req(0, 4'hF, 4'hF, 30'h300);
    set_req(1, 4'hF, 4'hF, 30'h400);
    req_ready_out = 4'b0011;
    push_req(1'b0, 4'hF, 8'h03, 30'h300);
    cyc();
    set_req(0, 4'b1100, 4'hF, 30'h300);
    req_ready_out = 4'b1100;
    push_req(1'b0, 4'b1100, 8'h0C, 30'h300);
    cyc();
    set_req(0, 4'hF, 4'hF, 30'h500);
    req_ready_out = 4'hF;
    push_req(1'b1, 4'hF, 8'hF0, 30'h400);
    cyc();
    clear_req();
    cyc();

    // Req1 load raises pending; full response clears it.
    set_req(1, 4'hF, 4'h0, 30'h600);
    push_req(1'b1, 4'hF, 8'hF0, 30'h600);
    cyc();
    check("pend_after_load1", 64'(pending_out), 64'h2);
    clear_req();
    send_rsp(4'hF, 16'hBEEF, 1'b1, 2'b11, 1'b1);
    cyc();
    rsp_valid_in = 1'b0;
    check("pend_after_rsp1", 64'(pending_out), 64'h0);

    // Same-cycle increment and decrement: 2 + 4 - 2 = 4, then drain 3 + 1.
    set_req(0, 4'b0011, 4'h0, 30'h700);
    push_req(1'b0, 4'b0011, 8'h0F, 30'h700);
    cyc();
    check("pend_cnt2", 64'(pending_out), 64'h1);
    set_req(0, 4'hF, 4'h0, 30'h710);
    push_req(1'b0, 4'hF, 8'h0F, 30'h710);
    send_rsp(4'b0011, 16'h0011, 1'b0, 2'b11, 1'b1);
    cyc();
    clear_req();
    send_rsp(4'b0111, 16'h0022, 1'b0, 2'b11, 1'b1);
    cyc();
    check("pend_cnt1_left", 64'(pending_out), 64'h1);
    send_rsp(4'b1000, 16'h0033, 1'b0, 2'b11, 1'b1);
    cyc();
    rsp_valid_in = 1'b0;
    check("pend_net_drained", 64'(pending_out), 64'h0);

    // Fill req0 to CAP-NUM_LANES+1 = 61 lanes.
    for (int k = 0; k < 15; k++) begin
      set_req(0, 4'hF, 4'h0, 30'h800 + 30'(k * 4));
      push_req(1'b0, 4'hF, 8'h0F, 30'h800 + 30'(k * 4));
      cyc();
    end
    set_req(0, 4'b0001, 4'h0, 30'h900);
    push_req(1'b0, 4'b0001, 8'h0F, 30'h900);
    cyc();
    check("pend_full", 64'(pending_out), 64'h1);
    set_req(0, 4'hF, 4'hF, 30'hA00);
    set_req(1, 4'hF, 4'hF, 30'hB00);
    push_req(1'b1, 4'hF, 8'hF0, 30'hB00);
    cyc();
    push_req(1'b1, 4'hF, 8'hF0, 30'hB00);
    cyc();
    clear_req();
    send_rsp(4'b0001, 16'h0044, 1'b0, 2'b11, 1'b1);
    cyc();
    rsp_valid_in = 1'b0;
    set_req(0, 4'hF, 4'hF, 30'hA00);
    set_req(1, 4'hF, 4'hF, 30'hB00);
    push_req(1'b0, 4'hF, 8'h0F, 30'hA00);
    cyc();
    clear_req();
    for (int k = 0; k < 15; k++) begin
      send_rsp(4'hF, 16'h0050 + 16'(k), 1'b0, 2'b11, 1'b1);
      cyc();
    end
    rsp_valid_in = 1'b0;
    check("pend_full_drained", 64'(pending_out), 64'h0);

    // Reset while req1 is locked with 8 lanes outstanding.
    set_req(1, 4'hF, 4'h0, 30'hC00);
    push_req(1'b1, 4'hF, 8'hF0, 30'hC00);
    cyc();
    set_req(1, 4'hF, 4'h0, 30'hC10);
    push_req(1'b1, 4'hF, 8'hF0, 30'hC10);
    cyc();
    check("pend_cnt8", 64'(pending_out), 64'h2);
    set_req(1, 4'hF, 4'h0, 30'hC20);
    req_ready_out = 4'h0;
    push_req(1'b1, 4'hF, 8'h00, 30'hC20);
    cyc();
    reset = 1'b0;
    clear_req();
    #1;
    check("midrst_pending", 64'(pending_out), 64'h0);
    check("midrst_valid_out", 64'(req_valid_out), 64'h0);
    cyc();
    reset = 1'b1;
    send_rsp(4'hF, 16'h0066, 1'b1, 2'b11, 1'b1);
    cyc();
    rsp_valid_in = 1'b0;
    check("late_rsp_sat", 64'(pending_out), 64'h0);
    set_req(0, 4'hF, 4'hF, 30'hD00);
    set_req(1, 4'hF, 4'hF, 30'hD10);
    req_ready_out = 4'hF;
    push_req(1'b0, 4'hF, 8'h0F, 30'hD00);
    cyc();
    clear_req();

    // Response back-pressure from requester 1 holds the counter.
    set_req(1, 4'hF, 4'h0, 30'hE00);
    push_req(1'b1, 4'hF, 8'hF0, 30'hE00);
    cyc();
    clear_req();
    check("pend_cnt4", 64'(pending_out), 64'h2);
    send_rsp(4'hF, 16'h0077, 1'b1, 2'b01, 1'b0);
    cyc();
    check("pend_held", 64'(pending_out), 64'h2);
    send_rsp(4'hF, 16'h0077, 1'b1, 2'b11, 1'b1);
    cyc();
    rsp_valid_in = 1'b0;
    check("pend_released", 64'(pending_out), 64'h0);

    repeat (2) cyc();
    check("req_q_empty", 64'(req_q.size()), 64'h0);
    check("rsp_q_empty", 64'(rsp_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
